// File: rtl/versat_databus_arbiter.sv
// Round-robin arbiter sharing one native databus master port among N_PORTS Versat I/O units.
// A granted unit keeps the bus for up to BURST_MAX completed transactions, or until it drops valid.
`ifndef IO_ADDR_W
`define IO_ADDR_W 32
`endif

module versat_databus_arbiter #(
   parameter int N_PORTS   = 4,
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = `IO_ADDR_W,
   parameter int BURST_MAX = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [N_PORTS-1:0]           s_valid,
   output logic [N_PORTS-1:0]           s_ready,
   input  logic [N_PORTS*ADDR_W-1:0]    s_addr,
   input  logic [N_PORTS*DATA_W-1:0]    s_wdata,
   input  logic [N_PORTS*DATA_W/8-1:0]  s_wstrb,
   output logic [N_PORTS*DATA_W-1:0]    s_rdata,
   output logic                         m_valid,
   input  logic                         m_ready,
   output logic [ADDR_W-1:0]            m_addr,
   output logic [DATA_W-1:0]            m_wdata,
   output logic [DATA_W/8-1:0]          m_wstrb,
   input  logic [DATA_W-1:0]            m_rdata,
   output logic [$clog2(N_PORTS)-1:0]   grant,
   output logic                         busy
);

   localparam int GW = $clog2(N_PORTS);
   localparam int SW = DATA_W / 8;
   localparam logic [8:0] BMAX = 9'(BURST_MAX);

   typedef enum logic {ST_IDLE, ST_BUSY} state_t;

   state_t          r_state;
   logic [GW-1:0]   r_grant;
   logic [GW-1:0]   r_last;
   logic [7:0]      r_cnt;
   logic            r_busy;

   logic [GW-1:0]   w_sel;
   logic            w_any;
   logic            w_own_valid;
   logic [8:0]      w_cnt_nxt;

   // Scan downward so the requester closest to last+1 is the final (winning) assignment.
   always_comb begin
      w_sel = r_last;
      w_any = 1'b0;
      for (int k = N_PORTS; k >= 1; k--) begin
         if (s_valid[(int'(r_last) + k) % N_PORTS]) begin
            w_sel = GW'((int'(r_last) + k) % N_PORTS);
            w_any = 1'b1;
         end
      end
   end

   assign w_own_valid = s_valid[r_grant];
   assign w_cnt_nxt   = {1'b0, r_cnt} + 9'd1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_grant <= '0;
         r_last  <= GW'(N_PORTS - 1);
         r_cnt   <= '0;
         r_busy  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_any) begin
                  r_grant <= w_sel;
                  r_cnt   <= '0;
                  r_state <= ST_BUSY;
                  r_busy  <= 1'b1;
               end
            end
            ST_BUSY: begin
               if (!w_own_valid) begin
                  r_last  <= r_grant;
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end else if (m_ready) begin
                  r_cnt <= w_cnt_nxt[7:0];
                  if (w_cnt_nxt == BMAX) begin
                     r_last  <= r_grant;
                     r_state <= ST_IDLE;
                     r_busy  <= 1'b0;
                  end
               end
            end
         endcase
      end
   end

   always_comb begin
      m_valid = (r_state == ST_BUSY) && w_own_valid;
      m_addr  = s_addr[r_grant*ADDR_W +: ADDR_W];
      m_wdata = s_wdata[r_grant*DATA_W +: DATA_W];
      m_wstrb = s_wstrb[r_grant*SW +: SW];
      s_ready = '0;
      if (m_valid && m_ready) s_ready[r_grant] = 1'b1;
   end

   assign s_rdata = {N_PORTS{m_rdata}};
   assign grant   = r_grant;
   assign busy    = r_busy;

endmodule

// File: tb/tb_versat_databus_arbiter.sv
// Randomized scoreboard bench for versat_databus_arbiter: per-port expected-transaction queues
// plus a round-robin ownership reference model checked every cycle.
module tb_versat_databus_arbiter;

   localparam int N  = 4;
   localparam int DW = 32;
   localparam int AW = 32;
   localparam int BM = 4;
   localparam int GW = 2;

   typedef struct packed {
      logic [AW-1:0]   addr;
      logic [DW-1:0]   wdata;
      logic [DW/8-1:0] wstrb;
   } txn_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic            v  [N];
   logic [AW-1:0]   a  [N];
   logic [DW-1:0]   wd [N];
   logic [DW/8-1:0] ws [N];

   logic [N-1:0]        s_valid;
   logic [N-1:0]        s_ready;
   logic [N*AW-1:0]     s_addr;
   logic [N*DW-1:0]     s_wdata;
   logic [N*DW/8-1:0]   s_wstrb;
   logic [N*DW-1:0]     s_rdata;
   logic                m_valid;
   logic                m_ready;
   logic [AW-1:0]       m_addr;
   logic [DW-1:0]       m_wdata;
   logic [DW/8-1:0]     m_wstrb;
   logic [DW-1:0]       m_rdata;
   logic [GW-1:0]       grant;
   logic                busy;

   always_comb begin
      s_valid = '0;
      s_addr  = '0;
      s_wdata = '0;
      s_wstrb = '0;
      for (int i = 0; i < N; i++) begin
         s_valid[i]               = v[i];
         s_addr[i*AW +: AW]       = a[i];
         s_wdata[i*DW +: DW]      = wd[i];
         s_wstrb[i*DW/8 +: DW/8]  = ws[i];
      end
   end

   versat_databus_arbiter #(
      .N_PORTS(N), .DATA_W(DW), .ADDR_W(AW), .BURST_MAX(BM)
   ) dut (
      .clk(clk), .rst(rst),
      .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr),
      .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_rdata(s_rdata),
      .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr),
      .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_rdata(m_rdata),
      .grant(grant), .busy(busy)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   txn_t exp_q [N][$];

   // Memory side: answers each valid request after 0..2 wait cycles with random read data.
   bit sl_en = 1'b0;
   int sl_wait = 0;
   initial begin
      m_ready = 1'b0;
      m_rdata = '0;
      forever begin
         @(posedge clk);
         #2;
         m_ready = 1'b0;
         if (sl_en && m_valid) begin
            if (sl_wait == 0) begin
               m_ready = 1'b1;
               m_rdata = $urandom;
               sl_wait = $urandom_range(0, 2);
            end else begin
               sl_wait--;
            end
         end
      end
   end

   // Reference: who owns the bus, how many transactions it has finished, and who released last.
   bit            mon_en  = 1'b0;
   int            m_owner = -1;
   int            m_cnt   = 0;
   int            m_last  = N - 1;
   logic [GW-1:0] m_grant = '0;

   always @(negedge clk) begin
      logic         exp_mv;
      logic [N-1:0] exp_sr;
      txn_t         e;
      bit           found;
      int           idx;
      if (mon_en) begin
         exp_mv = (m_owner >= 0) && v[m_owner];
         exp_sr = '0;
         if (exp_mv && m_ready) exp_sr[m_owner] = 1'b1;
         chk("busy", busy, (m_owner >= 0));
         chk("m_valid", m_valid, exp_mv);
         chk("s_ready", s_ready, exp_sr);
         chk("grant", grant, m_grant);
         if (exp_mv && m_ready) begin
            if (exp_q[m_owner].size() == 0) begin
               chk("unexpected_txn", 1, 0);
            end else begin
               e = exp_q[m_owner].pop_front();
               chk("m_addr", m_addr, e.addr);
               chk("m_wdata", m_wdata, e.wdata);
               chk("m_wstrb", m_wstrb, e.wstrb);
               chk("s_rdata", s_rdata[m_owner*DW +: DW], m_rdata);
               chk("s_rdata_bcast", (s_rdata == {N{m_rdata}}), 1);
            end
         end
         if (m_owner < 0) begin
            found = 1'b0;
            for (int k = 1; k <= N; k++) begin
               idx = (m_last + k) % N;
               if (!found && v[idx]) begin
                  found   = 1'b1;
                  m_owner = idx;
                  m_cnt   = 0;
                  m_grant = GW'(idx);
               end
            end
         end else if (!v[m_owner]) begin
            m_last  = m_owner;
            m_owner = -1;
         end else if (m_ready) begin
            m_cnt++;
            if (m_cnt == BM) begin
               m_last  = m_owner;
               m_owner = -1;
            end
         end
      end
   end

   task automatic run_port(input int p, input int n);
      int   gap;
      bit   got;
      txn_t x;
      for (int t = 0; t < n; t++) begin
         gap = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
         if (gap > 0) begin
            v[p] = 1'b0;
            repeat (gap) @(posedge clk);
            #1;
         end
         x.addr  = $urandom;
         x.wdata = $urandom;
         x.wstrb = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
         a[p]  = x.addr;
         wd[p] = x.wdata;
         ws[p] = x.wstrb;
         exp_q[p].push_back(x);
         v[p] = 1'b1;
         got = 1'b0;
         for (int c = 0; c < 300 && !got; c++) begin
            @(negedge clk);
            if (s_ready[p]) got = 1'b1;
         end
         chk("ready_timeout", got, 1);
         if (!got) begin
            v[p] = 1'b0;
            return;
         end
         @(posedge clk);
         #1;
      end
      v[p] = 1'b0;
   endtask

   initial begin
      bit seen;
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit seen;
      for (int i = 0; i < N; i++) begin
         v[i] = 1'b0; a[i] = '0; wd[i] = '0; ws[i] = '0;
      end
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_m_valid", m_valid, 0);
      chk("rst_s_ready", s_ready, 0);
      chk("rst_grant", grant, 0);
      rst = 1'b0;
      mon_en = 1'b1;
      sl_en  = 1'b1;

      fork
         run_port(0, 25);
         run_port(1, 25);
         run_port(2, 25);
         run_port(3, 25);
      join

      repeat (5) @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) chk("queue_drained", exp_q[i].size(), 0);

      // Reset while a request is outstanding on the master side.
      mon_en = 1'b0;
      sl_en  = 1'b0;
      a[2] = 32'h100; wd[2] = 32'h0; ws[2] = 4'h0;
      v[2] = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 10 && !seen; c++) begin
         @(negedge clk);
         if (m_valid) seen = 1'b1;
      end
      chk("pre_rst_m_valid", seen, 1);
      #1;
      rst = 1'b1;
      #1;
      chk("async_rst_m_valid", m_valid, 0);
      chk("async_rst_busy", busy, 0);
      chk("async_rst_s_ready", s_ready, 0);
      chk("async_rst_grant", grant, 0);
      @(posedge clk);
      #1;
      v[0] = 1'b1;
      a[0] = 32'h200;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_arb_m_valid", m_valid, 0);
      chk("post_rst_arb_busy", busy, 0);
      @(negedge clk);
      chk("post_rst_busy", busy, 1);
      chk("post_rst_grant", grant, 0);
      chk("post_rst_m_valid", m_valid, 1);
      chk("post_rst_m_addr", m_addr, 32'h200);
      v[0] = 1'b0;
      v[2] = 1'b0;
      repeat (2) @(posedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/versat_databus_arbiter.md
Name: versat_databus_arbiter

Overview:
- Shares one native databus master port among N_PORTS Versat I/O units (VRead/VWrite-style units, each with its own ext_addrgen).
- Uses round-robin arbitration with grant locking. A granted unit may issue up to BURST_MAX back-to-back transactions before it must release the bus.
- Sits between the I/O unit databus ports and the system memory interface. It is purely a sequencer/multiplexer and does not modify data.

Parameters:
- N_PORTS, 4, number of requesting units (2..8)
- DATA_W, 32, databus data width
- ADDR_W, `IO_ADDR_W, databus address width
- BURST_MAX, 4, maximum consecutive completed transactions per grant (1..255)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- s_valid  in  N_PORTS  per-unit request valid
- s_ready  out  N_PORTS  per-unit completion strobe
- s_addr  in  N_PORTS*ADDR_W  per-unit address; slice i = [i*ADDR_W +: ADDR_W]
- s_wdata  in  N_PORTS*DATA_W  per-unit write data
- s_wstrb  in  N_PORTS*DATA_W/8  per-unit write strobes; all-zero = read
- s_rdata  out  N_PORTS*DATA_W  read data, broadcast to every slice
- m_valid  out  1  master request valid
- m_ready  in  1  master completion, one-cycle pulse
- m_addr  out  ADDR_W  master address
- m_wdata  out  DATA_W  master write data
- m_wstrb  out  DATA_W/8  master write strobes
- m_rdata  in  DATA_W  master read data, valid when m_ready=1
- grant  out  $clog2(N_PORTS)  index of current or last owner (debug)
- busy  out  1  1 while in BUSY state

Behaviour:
- Native protocol on both sides:
  - A requester holds valid, addr, wdata and wstrb stable until it sees ready.
  - ready is a one-cycle pulse that completes exactly one transaction.
- FSM states: IDLE, BUSY.
- Reset values: state=IDLE, grant=0, burst_cnt=0, last=N_PORTS-1, m_valid=0, s_ready=0, busy=0.
- Reset mid-transaction discards the in-flight transaction with no completion strobe. The master side must be reset together with the arbiter.
- IDLE:
  - m_valid=0 and s_ready=0.
  - If any s_valid is high, select the first requester with s_valid=1 scanning from (last+1) mod N_PORTS upward with wrap.
  - Register the selection into grant, clear burst_cnt, and go to BUSY.
  - Arbitration costs exactly 1 cycle: m_valid first rises the cycle after s_valid is seen in IDLE.
- BUSY forwarding (combinational):
  - m_valid = s_valid[grant]
  - m_addr, m_wdata and m_wstrb = slice[grant]
  - s_ready = m_ready << grant; only the owner receives ready
  - s_rdata = m_rdata replicated on all slices
- BUSY completion: when m_valid & m_ready, burst_cnt increments. If burst_cnt+1 == BURST_MAX:
  - set last=grant and return to IDLE;
  - m_valid is 0 on the next cycle.
- BUSY release: when s_valid[grant]=0, set last=grant and go to IDLE. This is legal only between transactions; m_valid is already 0 that cycle.
- Burst continuation: if the owner reasserts s_valid the cycle after its s_ready and burst_cnt < BURST_MAX, it keeps the bus with no arbitration bubble.
- Fairness: after releasing, the owner has lowest priority. Worst-case wait for any requester = (N_PORTS-1)*(BURST_MAX+1) transactions plus slots.
- Simultaneous events:
  - New requests arriving while BUSY are ignored until IDLE.
  - A requester that drops valid before being granted is simply skipped.
- Outputs when not granted: m_addr, m_wdata and m_wstrb are don't-care while m_valid=0; the implementation drives slice[grant].
- busy=1 iff state==BUSY. grant holds its value in IDLE.

Test Plan:
- Reset then single request: rst pulse; s_valid=4'b0001, addr=0x100, m_ready 2 cycles after m_valid.
  - Required: m_valid rises 1 cycle after s_valid; m_addr=0x100; s_ready=4'b0001 for one cycle; grant=0.
- Round-robin with all 4 requesting continuously, BURST_MAX=1:
  - Required: grant sequence 0,1,2,3,0; exactly one IDLE cycle between owners; no starvation over 40 transactions.
- Burst limit, BURST_MAX=4: port 2 requests 6 back-to-back reads; port 0 also pending.
  - Required: port 2 completes 4, bus goes to port 0, then port 2 completes the remaining 2.
- Early release: port 1 issues 2 writes (wstrb=4'hF, wdata=0xDEADBEEF), then drops valid; port 3 pending.
  - Required: m_wdata=0xDEADBEEF on both; grant moves to port 3 after 1 IDLE cycle.
- Read data routing: port 3 read with m_rdata=0xCAFE0003 on m_ready.
  - Required: s_ready=4'b1000 only; slice 3 of s_rdata=0xCAFE0003.
- Reset mid-transaction: assert rst while m_valid=1 and before m_ready.
  - Required: m_valid=0, s_ready=0, busy=0 immediately (async); after deassert, arbitration restarts from port 0.
